// File: rtl/delay_pipeline_pkg.sv
// Shared helpers for the delay_pipeline block: sizing of the occupancy counter.
package delay_pipeline_pkg;

   // Occupancy counter width: enough bits to hold 0..cycles, never narrower than 1.
   function automatic int count_width(input int cycles);
      if (cycles < 1) return 1;
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/delay_pipeline_delay_stage.sv
// One register stage of the delay line: data word plus its valid bit.
module delay_stage #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] in,
   output logic             valid_out,
   output logic [WIDTH-1:0] out
);

   // Data keeps moving through a flush so its content stays deterministic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= RESET_VALUE;
      else if (en)
         out <= in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid_out <= 1'b0;
      else if (flush)
         valid_out <= 1'b0;
      else if (en)
         valid_out <= valid_in;
   end

endmodule

// File: rtl/delay_pipeline.sv
// CYCLES-deep delay line with per-stage valid, stall, flush and occupancy count.
module delay_pipeline
   import delay_pipeline_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               CYCLES      = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            flush,
   input  logic                            valid_in,
   input  logic [WIDTH-1:0]                in,
   output logic                            valid_out,
   output logic [WIDTH-1:0]                out,
   output logic [count_width(CYCLES)-1:0]  count
);

   localparam int CW = count_width(CYCLES);

   if (CYCLES == 0) begin : g_bypass
      // Zero latency: wire straight through; the control inputs are intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en, flush};
      assign out         = in;
      assign valid_out   = valid_in;
      assign count       = '0;
   end else begin : g_pipe
      // Index 0 is the pipeline input, index CYCLES the last register stage.
      logic [WIDTH-1:0] data_p [CYCLES+1];
      logic             vld_p  [CYCLES+1];
      logic [CW-1:0]    count_q;
      logic [CW-1:0]    count_next;

      assign data_p[0] = in;
      assign vld_p[0]  = valid_in;

      for (genvar i = 0; i < CYCLES; i++) begin : g_stage
         delay_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .valid_in  (vld_p[i]),
            .in        (data_p[i]),
            .valid_out (vld_p[i+1]),
            .out       (data_p[i+1])
         );
      end

      // One sample enters and one may leave per enabled edge; the modular sum stays in range.
      always_comb begin
         count_next = count_q + CW'(valid_in) - CW'(vld_p[CYCLES]);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            count_q <= '0;
         else if (flush)
            count_q <= '0;
         else if (en)
            count_q <= count_next;
      end

      assign out       = data_p[CYCLES];
      assign valid_out = vld_p[CYCLES];
      assign count     = count_q;
   end

endmodule

// File: tb/tb_delay_pipeline.sv
// Bench for delay_pipeline: CYCLES=4 instance against a model and scoreboard, plus a CYCLES=0 instance.
module tb_delay_pipeline;

   localparam int         W  = 8;
   localparam int         C  = 4;
   localparam logic [7:0] RV = 8'h5A;

   logic       clk = 1'b0;
   logic       rst, en, flush, valid_in;
   logic [7:0] din, dout;
   logic       valid_out;
   logic [2:0] count;

   logic       vin0, vout0;
   logic [7:0] din0, dout0;
   logic [0:0] count0;

   int checks = 0;
   int errors = 0;

   logic [7:0] q [$];
   logic [7:0] mdat [C];
   logic       mvld [C];

   always #5 clk = ~clk;

   delay_pipeline #(.WIDTH(W), .CYCLES(C), .RESET_VALUE(RV)) u_dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in), .in(din),
      .valid_out(valid_out), .out(dout), .count(count)
   );

   delay_pipeline #(.WIDTH(W), .CYCLES(0), .RESET_VALUE(RV)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(vin0), .in(din0),
      .valid_out(vout0), .out(dout0), .count(count0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int pop_vld();
      int n = 0;
      for (int i = 0; i < C; i++) n += int'(mvld[i]);
      return n;
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < C; i++) begin
         mdat[i] = RV;
         mvld[i] = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [31:0] exp_front;
      chk("out", 32'(dout), 32'(mdat[C-1]));
      chk("valid_out", 32'(valid_out), 32'(mvld[C-1]));
      chk("count_popcount", 32'(count), 32'(pop_vld()));
      chk("count_queue", 32'(count), 32'(q.size()));
      if (valid_out) begin
         exp_front = (q.size() > 0) ? 32'(q[0]) : 32'hxxxxxxxx;
         chk("order", 32'(dout), exp_front);
      end
   endtask

   // Drive one clock: inputs applied now, model advanced at the edge, outputs checked at negedge.
   task automatic cycle(input logic e, input logic f, input logic v, input logic [7:0] d);
      en = e; flush = f; valid_in = v; din = d;
      @(posedge clk);
      if (e && !f && mvld[C-1]) void'(q.pop_front());
      if (f) q.delete();
      else if (e && v) q.push_back(d);
      if (e) begin
         for (int i = C-1; i > 0; i--) begin
            mdat[i] = mdat[i-1];
            mvld[i] = mvld[i-1];
         end
         mdat[0] = d;
         mvld[0] = v;
      end
      if (f) for (int i = 0; i < C; i++) mvld[i] = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         exp_cnt [7] = '{1, 2, 3, 3, 2, 1, 0};
      logic [7:0] exp_out [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h00};
      logic       exp_v   [7] = '{0, 0, 0, 1, 1, 1, 0};

      rst = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0; din = '0;
      vin0 = 1'b0; din0 = '0;
      model_reset();
      #12;
      chk("reset_out", 32'(dout), 32'(RV));
      chk("reset_valid", 32'(valid_out), 0);
      chk("reset_count", 32'(count), 0);
      rst = 1'b0;
      @(negedge clk);

      // Three valid samples then bubbles.
      for (int k = 0; k < 7; k++) begin
         cycle(1'b1, 1'b0, k < 3, (k < 3) ? 8'(k + 1) : 8'h00);
         chk("basic_count", 32'(count), 32'(exp_cnt[k]));
         chk("basic_out", 32'(dout), 32'(exp_out[k]));
         chk("basic_valid", 32'(valid_out), 32'(exp_v[k]));
      end

      // Stall with a valid sample in flight.
      cycle(1'b1, 1'b0, 1'b1, 8'hAA);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
         chk("stall_count", 32'(count), 1);
         chk("stall_valid", 32'(valid_out), 0);
      end
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stall_out", 32'(dout), 32'hAA);
      chk("stall_valid_out", 32'(valid_out), 1);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // Flush with three samples in flight and a valid input at the flush edge.
      cycle(1'b1, 1'b0, 1'b1, 8'h11);
      cycle(1'b1, 1'b0, 1'b1, 8'h22);
      cycle(1'b1, 1'b0, 1'b1, 8'h33);
      chk("preflush_count", 32'(count), 3);
      cycle(1'b1, 1'b1, 1'b1, 8'h55);
      chk("flush_count", 32'(count), 0);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'h00);
         chk("flush_valid", 32'(valid_out), 0);
      end

      // Asynchronous reset between edges.
      cycle(1'b1, 1'b0, 1'b1, 8'h61);
      cycle(1'b1, 1'b0, 1'b1, 8'h62);
      chk("prereset_count", 32'(count), 2);
      en = 1'b0; valid_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("areset_out", 32'(dout), 32'(RV));
      chk("areset_valid", 32'(valid_out), 0);
      chk("areset_count", 32'(count), 0);
      model_reset();
      #1 rst = 1'b0;
      @(negedge clk);
      check_all();
      cycle(1'b1, 1'b0, 1'b1, 8'h77);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      chk("post_reset_out", 32'(dout), 32'h77);
      chk("post_reset_valid", 32'(valid_out), 1);

      // Zero-latency build: follows input immediately, ignores flush and reset.
      en = 1'b0; flush = 1'b0; valid_in = 1'b0;
      din0 = 8'h00; vin0 = 1'b0;
      #1;
      chk("bypass_out_lo", 32'(dout0), 0);
      chk("bypass_valid_lo", 32'(vout0), 0);
      din0 = 8'hFF; vin0 = 1'b1;
      #1;
      chk("bypass_out_hi", 32'(dout0), 32'hFF);
      chk("bypass_valid_hi", 32'(vout0), 1);
      chk("bypass_count", 32'(count0), 0);
      rst = 1'b1; flush = 1'b1;
      #1;
      chk("bypass_rst_out", 32'(dout0), 32'hFF);
      chk("bypass_rst_valid", 32'(vout0), 1);
      chk("bypass_rst_count", 32'(count0), 0);
      model_reset();
      rst = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_all();

      // Random stress against the model and scoreboard.
      for (int k = 0; k < 10000; k++) begin
         din0 = 8'($urandom);
         vin0 = ($urandom_range(0, 1) == 1);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 1, 8'($urandom));
         if (k % 100 == 0) begin
            chk("rand_bypass_out", 32'(dout0), 32'(din0));
            chk("rand_bypass_valid", 32'(vout0), 32'(vin0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_pipeline.md
Name: delay_pipeline

Overview:
- Parametrised multi-stage delay line with a per-stage valid bit, global enable (stall), synchronous flush and an occupancy count.
- Generalises the single enabled register to CYCLES stages with configurable reset value.
- Used to balance latency across datapath branches, e.g. aligning control with an N-cycle arithmetic unit, while tracking which samples in flight are meaningful.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- CYCLES, 4, number of register stages, i.e. latency in enabled cycles (>=0).
- RESET_VALUE, '0 (WIDTH bits), value loaded into every data stage on reset.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset: asynchronous, active-high.
- en, input, 1, advance the pipeline when 1; hold all stages when 0.
- flush, input, 1, synchronous clear of all valid bits and count.
- valid_in, input, 1, marks in as meaningful.
- in, input, WIDTH, data entering stage 0.
- valid_out, output, 1, valid bit of the last stage.
- out, output, WIDTH, data of the last stage.
- count, output, $clog2(CYCLES+1) (min 1), number of valid samples currently held.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all data stages = RESET_VALUE; all valid bits = 0; count = 0.
  - out = RESET_VALUE, valid_out = 0 while reset is held.
- Rising edge with en=1, flush=0:
  - stage[0] <= {valid_in, in}; stage[i] <= stage[i-1] for i = 1..CYCLES-1.
  - A sample presented on cycle t appears on out/valid_out after exactly CYCLES enabled edges.
- Rising edge with en=0, flush=0: every stage and count hold, including when valid_in=1; the input sample is dropped.
- Rising edge with flush=1 (any en): all valid bits <= 0 and count <= 0.
  - The incoming valid_in is discarded as well.
  - Data stages shift if en=1 and hold if en=0; data content after a flush is don't-care for consumers but must be deterministic.
- count update on an en=1, flush=0 edge: count <= count + valid_in − valid_out(current).
  - Never exceeds CYCLES; never underflows.
  - count always equals popcount of the valid bits. This is an invariant the bench asserts every cycle.
- Outputs are registered (last stage). There is no combinational path from in, en or flush to out, valid_out or count when CYCLES>=1.
- CYCLES=0 (degenerate mode):
  - out = in, valid_out = valid_in, purely combinational.
  - count = 0 constant; en, flush, rst and clk have no effect.
- CYCLES=1: single-stage register with valid bit; count ∈ {0,1}.
- Reset mid-operation: all in-flight samples are lost. The first post-reset sample emerges after CYCLES enabled edges.
- Invalid samples (valid_in=0) still shift their data through, so out follows in delayed by CYCLES regardless of valid.

Decomposition:
- No shared package types required.
- count width is a localparam computed as max(1, $clog2(CYCLES+1)).
- One natural sub-module: delay_stage (WIDTH+1-bit register with en, async rst, RESET_VALUE, synchronous valid clear on flush).
- The top instantiates CYCLES delay_stage instances via generate, adds the count register, and uses a generate branch for CYCLES=0.

Test Plan:
- WIDTH=8, CYCLES=4, en=1: drive valid_in=1 with in=0x01,0x02,0x03 on cycles 0–2 -> out=0x01,0x02,0x03 with valid_out=1 on cycles 4–6; count goes 1,2,3,3,2,1,0.
- Stall: load 0xAA (valid), hold en=0 for 5 cycles -> out, valid_out and count frozen; then en=1 -> 0xAA emerges after 4 total enabled edges.
- Flush: 3 valid samples in flight (count=3); assert flush with en=1 and valid_in=1, in=0x55 -> next cycle count=0, valid_out stays 0 for the next 4 cycles.
- Async reset mid-stream: with count=2, pulse rst between clock edges -> out=RESET_VALUE (test 0x5A) and valid_out=0, count=0 immediately, before the next edge.
- CYCLES=0 build: toggle in 0x00->0xFF and valid_in -> out and valid_out follow in the same delta, count=0; flush and rst have no effect.
- Random stress: random en/flush/valid_in for 10k cycles against a scoreboard queue -> every valid output matches in order; count equals popcount of valids every cycle.
